// File: rtl/switch_mcu_ex_alu_rr.sv
// rtl/switch_mcu_ex_alu_rr.sv - register-read ALU execute stage; optional multiply enabled by SWITCH_MCU_ALU_MUL_EN
module switch_mcu_ex_alu_rr #(
  parameter int XLEN   = 32,
  parameter int RF_AW  = 5,
  parameter int RD_LAT = 2
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_start,
  input  logic             in_flush,
  input  logic [3:0]       in_op,
  input  logic [RF_AW-1:0] in_rs1,
  input  logic [RF_AW-1:0] in_rs2,
  input  logic [RF_AW-1:0] in_rd,
  output logic             out_ren_1,
  output logic [RF_AW-1:0] out_raddr_1,
  output logic             out_ren_2,
  output logic [RF_AW-1:0] out_raddr_2,
  input  logic [XLEN-1:0]  in_rdata_1,
  input  logic [XLEN-1:0]  in_rdata_2,
  output logic             out_wen,
  output logic [RF_AW-1:0] out_waddr,
  output logic [XLEN-1:0]  out_wdata,
  output logic             out_busy,
  output logic             out_done,
  output logic             out_illegal
);

  localparam int SHW = $clog2(XLEN);
  // Counter starts at RD_LAT-1 so the capture lands exactly RD_LAT cycles after READ.
  localparam logic [2:0] CNT_LOAD = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, READ, WAIT, WB} state_t;

  state_t           state_q, state_d;
  logic             accept;
  logic [3:0]       op_q;
  logic [RF_AW-1:0] rs1_q, rs2_q, rd_q;
  logic [2:0]       cnt_q;
  logic [XLEN-1:0]  a_q, b_q;
  logic [XLEN-1:0]  alu_res;
  logic             alu_ill;
  logic [SHW-1:0]   shamt;

  assign shamt = b_q[SHW-1:0];

  // State register plus captured request, latency counter and operands.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= in_op;
        rs1_q <= in_rs1;
        rs2_q <= in_rs2;
        rd_q  <= in_rd;
      end
      if (state_q == READ) begin
        cnt_q <= CNT_LOAD;
      end else if (state_q == WAIT && cnt_q != 3'd0) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if (state_q == WAIT && !in_flush && cnt_q == 3'd0) begin
        a_q <= in_rdata_1;
        b_q <= in_rdata_2;
      end
    end
  end

  // Next state and all outputs; outputs are pure functions of state so reset clears them at once.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    out_ren_1   = 1'b0;
    out_raddr_1 = '0;
    out_ren_2   = 1'b0;
    out_raddr_2 = '0;
    out_wen     = 1'b0;
    out_waddr   = '0;
    out_wdata   = '0;
    out_busy    = 1'b0;
    out_done    = 1'b0;
    out_illegal = 1'b0;
    case (state_q)
      IDLE: begin
        // Flush outranks start while idle.
        if (in_start && !in_flush) begin
          accept  = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        out_ren_1   = 1'b1;
        out_raddr_1 = rs1_q;
        out_ren_2   = 1'b1;
        out_raddr_2 = rs2_q;
        out_busy    = 1'b1;
        state_d     = in_flush ? IDLE : WAIT;
      end
      WAIT: begin
        out_busy = 1'b1;
        if (in_flush) begin
          state_d = IDLE;
        end else if (cnt_q == 3'd0) begin
          state_d = WB;
        end
      end
      WB: begin
        out_done    = 1'b1;
        out_illegal = alu_ill;
        out_waddr   = rd_q;
        out_wen     = !alu_ill && (rd_q != '0);
        out_wdata   = alu_ill ? '0 : alu_res;
        // Flush is ignored here; a new start chains straight into READ.
        if (in_start) begin
          accept  = 1'b1;
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result of the captured operands; anything not decoded is flagged illegal.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op_q)
      4'd0: alu_res = a_q + b_q;
      4'd1: alu_res = a_q - b_q;
      4'd2: alu_res = a_q << shamt;
      4'd3: alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      4'd4: alu_res = {{(XLEN-1){1'b0}}, (a_q < b_q)};
      4'd5: alu_res = a_q ^ b_q;
      4'd6: alu_res = a_q >> shamt;
      4'd7: alu_res = $signed(a_q) >>> shamt;
      4'd8: alu_res = a_q | b_q;
      4'd9: alu_res = a_q & b_q;
`ifdef SWITCH_MCU_ALU_MUL_EN
      4'd10: alu_res = a_q * b_q;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

endmodule

// File: doc/switch_mcu_ex_alu_rr.md
SWITCH_MCU_EX_ALU_RR -- requirements
Module: switch_mcu_ex_alu_rr

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- XLEN, 32: operand/result width.
- RF_AW, 5: register-file address width.
- RD_LAT, 2: register-file read latency in cycles, 1..4.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- in_clk, in, 1: clock, rising edge.
- in_rst, in, 1: reset, asynchronous, active-low.
- in_start, in, 1: operation request, sampled in IDLE only.
- in_flush, in, 1: synchronous abort.
- in_op, in, 4: opcode. 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL, 11-15 reserved.
- in_rs1, in_rs2, in_rd, in, RF_AW: source and destination indices.
- out_ren_1/out_raddr_1, out_ren_2/out_raddr_2, out, 1/RF_AW: read ports.
- in_rdata_1, in_rdata_2, in, XLEN: read data.
- out_wen, out_waddr, out_wdata, out, 1/RF_AW/XLEN: write port.
- out_busy, out_done, out_illegal, out, 1: status.
REQ-003 Clock SHALL be in_clk; reset SHALL be in_rst, asynchronous, active-low.

Function
REQ-004 The FSM SHALL have states IDLE, READ, WAIT, WB.
REQ-005 In IDLE, in_start=1 SHALL register in_op, in_rs1, in_rs2 and in_rd, then go to READ.
REQ-006 In READ (one cycle), out_ren_1/2 SHALL be 1 with out_raddr_1/2=rs1/rs2. The next state SHALL be WAIT; a read-latency counter SHALL load RD_LAT-1.
REQ-007 WAIT SHALL hold ren=0 and raddr=0, and decrement the counter. When the counter is 0, it SHALL capture in_rdata_1/2 and go to WB. in_rdata is valid exactly RD_LAT cycles after the READ cycle.
REQ-008 WB SHALL last one cycle and return to IDLE. In WB: out_done=1; out_wen=1 and out_waddr=rd, except that out_wen=0 when rd==0 or the op is illegal.
REQ-009 Latency: in_start high at cycle T produces out_done in cycle T+RD_LAT+2.
REQ-010 out_busy SHALL be 1 in READ and WAIT and 0 in IDLE and WB. in_start in WB SHALL be accepted, giving back-to-back operations.
REQ-011 in_start while busy SHALL be ignored (no queueing).
REQ-012 Arithmetic: all ops SHALL be XLEN-wide modulo 2^XLEN.
- Shift amount SHALL be rdata_2[$clog2(XLEN)-1:0] for SLL, SRL and SRA.
- SLT/SLTU SHALL give {XLEN-1 zeros, flag}.
REQ-013 A reserved opcode SHALL set out_illegal=1 with out_done in WB, and out_wdata=0.
REQ-014 in_flush=1 in READ or WAIT SHALL return to IDLE next edge: no WB, no done, no wen. In WB, flush SHALL have no effect. In IDLE, flush SHALL take priority over start.
REQ-015 Outside the pulses above, all outputs SHALL be 0: ren, raddr, wen, waddr, wdata, done, illegal.

Reset
REQ-016 in_rst=0 SHALL immediately force state IDLE, counter 0, all captured registers 0, and every output 0.
REQ-017 Reset asserted mid-operation SHALL discard the operation; after release, the block SHALL accept in_start in the first clock.

Configuration
REQ-018 Macro SWITCH_MCU_ALU_MUL_EN:
- Defined: op 10 SHALL write the low XLEN bits of the unsigned product rdata_1*rdata_2, with normal WB timing.
- Undefined: op 10 SHALL be reserved (REQ-013), and no multiplier SHALL be synthesised.

Verification
REQ-019 RD_LAT=2, ADD rs1=3(0x5), rs2=4(0x7), rd=6, start at T: ren both at T+1 with addr 3/4. Required: wen=1, waddr=6, wdata=0xC, done=1 at T+4; busy low at T+4.
REQ-020 SRA rdata_1=0x8000_0000, rdata_2=0x0000_0024: wdata=0xF800_0000 (shamt 4). SLT 0xFFFF_FFFF vs 0x1: wdata=1. SLTU same operands: wdata=0.
REQ-021 Back-to-back: start held high at T and T+4 (in WB). Required: second READ at T+5, second done at T+8; start at T+2 ignored.
REQ-022 in_flush at T+2 during WAIT: no done/wen through T+6; new start at T+3 completes normally. rd=0 ADD: done=1, wen=0.
REQ-023 in_op=12: done=1, illegal=1, wen=0, wdata=0. op 10 with 0x10000×0x10000: with SWITCH_MCU_ALU_MUL_EN wdata=0x0, wen=1; without, illegal=1.
REQ-024 Assert in_rst low at T+2: all outputs 0 asynchronously. Release at T+4 with start high: READ at T+5. Repeat the REQ-019 case with RD_LAT=1 and RD_LAT=4: done at T+3 and T+6.
